// File: rtl/fast_serial_pkg.sv
// Shared definitions for the C128 fast-serial peer: TX state encoding, line levels
// and the tick-counter width helper.
package fast_serial_pkg;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t TX_IDLE = 2'd0;
   localparam tx_state_t TX_LOW  = 2'd1;
   localparam tx_state_t TX_HIGH = 2'd2;
   localparam tx_state_t TX_GAP  = 2'd3;

   // SP and CNT are open-collector style lines that float high when released.
   localparam logic LINE_IDLE = 1'b1;

   // The extra bit lets a counter hold the full terminal value without wrapping.
   function automatic int tick_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/fsp_line_sync.sv
// Two-flop synchronizer for one serial line, with a rising-edge detect on the synced level.
module fsp_line_sync
   import fast_serial_pkg::*;
(
   input  logic clk,
   input  logic res_n,
   input  logic din,
   output logic dout,
   output logic rise
);

   logic meta;
   logic sync;
   logic prev;

   // Flops reset to the released level so leaving reset never looks like an edge.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         meta <= LINE_IDLE;
         sync <= LINE_IDLE;
         prev <= LINE_IDLE;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign dout = sync;
   assign rise = sync & ~prev;

endmodule

// File: rtl/fast_serial_peer.sv
// Device-side endpoint of the C128 fast-serial link: receives host-clocked bytes on SP/CNT
// and transmits bytes with a locally generated CNT, MSB first.
module fast_serial_peer
   import fast_serial_pkg::*;
#(
   parameter int HALF_TICKS = 4,
   parameter int GAP_TICKS  = 8,
   parameter int RX_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ce,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       rx_busy,
   input  logic       sp_in,
   input  logic       cnt_in,
   output logic       sp_out,
   output logic       cnt_out
);

   localparam int TW = tick_width(HALF_TICKS, GAP_TICKS, RX_TIMEOUT);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
   localparam logic [TW-1:0] RXTO_LAST = TW'(RX_TIMEOUT - 1);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);

   logic          sp_sync;
   logic          sp_rise_unused;
   logic          cnt_sync_unused;
   logic          cnt_rise;

   tx_state_t     state;
   logic [TW-1:0] tx_tick;
   logic [2:0]    tx_bit;
   logic [6:0]    txsh;
   logic          ready_en;

   logic [6:0]    shreg;
   logic [7:0]    shreg_next;
   logic [2:0]    bitcnt;
   logic [TW-1:0] rx_tick;
   logic          rx_fire;
   logic          rx_complete;
   logic          accept;

   fsp_line_sync u_sp_sync (
      .clk   (clk),
      .res_n (res_n),
      .din   (sp_in),
      .dout  (sp_sync),
      .rise  (sp_rise_unused)
   );

   fsp_line_sync u_cnt_sync (
      .clk   (clk),
      .res_n (res_n),
      .din   (cnt_in),
      .dout  (cnt_sync_unused),
      .rise  (cnt_rise)
   );

   // Our own CNT drive shows up on cnt_in while transmitting, so RX only listens when idle.
   assign rx_fire     = cnt_rise & (state == TX_IDLE);
   assign rx_complete = rx_fire & (bitcnt == 3'd7);
   assign shreg_next  = {shreg, sp_sync};
   assign rx_busy     = (bitcnt != 3'd0);

   assign tx_ready = ready_en & (state == TX_IDLE) & ~rx_busy & ~rx_fire;
   assign accept   = tx_valid & tx_ready;

   // Receive shifter, mid-byte timeout and the consumer handshake.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         shreg      <= 7'h00;
         bitcnt     <= 3'd0;
         rx_tick    <= '0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (rx_fire) begin
            shreg   <= shreg_next[6:0];
            rx_tick <= '0;
            if (bitcnt == 3'd7) begin
               bitcnt  <= 3'd0;
               rx_data <= shreg_next;
            end else begin
               bitcnt <= bitcnt + 3'd1;
            end
         end else if (ce && rx_busy) begin
            if (rx_tick == RXTO_LAST) begin
               bitcnt  <= 3'd0;
               rx_tick <= '0;
            end else begin
               rx_tick <= rx_tick + TICK_ONE;
            end
         end

         // A fresh byte always wins over a simultaneous ack.
         if (rx_complete) begin
            rx_valid <= 1'b1;
            if (rx_ack) begin
               rx_overrun <= 1'b0;
            end else if (rx_valid) begin
               rx_overrun <= 1'b1;
            end
         end else if (rx_ack) begin
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
         end
      end
   end

   // Transmit FSM: data changes with each CNT fall so it is stable a half-period before the rise.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state    <= TX_IDLE;
         tx_tick  <= '0;
         tx_bit   <= 3'd0;
         txsh     <= 7'h00;
         sp_out   <= LINE_IDLE;
         cnt_out  <= LINE_IDLE;
         tx_done  <= 1'b0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         tx_done  <= 1'b0;
         case (state)
            TX_IDLE: begin
               if (accept) begin
                  txsh    <= tx_data[6:0];
                  sp_out  <= tx_data[7];
                  cnt_out <= 1'b0;
                  tx_tick <= '0;
                  tx_bit  <= 3'd0;
                  state   <= TX_LOW;
               end
            end
            TX_LOW: begin
               if (ce) begin
                  if (tx_tick == HALF_LAST) begin
                     tx_tick <= '0;
                     cnt_out <= 1'b1;
                     state   <= TX_HIGH;
                  end else begin
                     tx_tick <= tx_tick + TICK_ONE;
                  end
               end
            end
            TX_HIGH: begin
               if (ce) begin
                  if (tx_tick == HALF_LAST) begin
                     tx_tick <= '0;
                     if (tx_bit == 3'd7) begin
                        sp_out <= LINE_IDLE;
                        state  <= TX_GAP;
                     end else begin
                        tx_bit  <= tx_bit + 3'd1;
                        txsh    <= {txsh[5:0], 1'b0};
                        sp_out  <= txsh[6];
                        cnt_out <= 1'b0;
                        state   <= TX_LOW;
                     end
                  end else begin
                     tx_tick <= tx_tick + TICK_ONE;
                  end
               end
            end
            TX_GAP: begin
               sp_out  <= LINE_IDLE;
               cnt_out <= LINE_IDLE;
               if (ce) begin
                  if (tx_tick == GAP_LAST) begin
                     tx_tick <= '0;
                     tx_done <= 1'b1;
                     state   <= TX_IDLE;
                  end else begin
                     tx_tick <= tx_tick + TICK_ONE;
                  end
               end
            end
            default: begin
               state <= TX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fast_serial_peer.sv
// Self-checking bench for fast_serial_peer: a host model drives SP/CNT and watches the
// transmitter, comparing against expectations derived from the byte-level protocol.
module tb_fast_serial_peer;

   localparam int HALF = 4;
   localparam int GAP  = 8;
   localparam int RXTO = 64;

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       ce = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_done;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ack = 1'b0;
   logic       rx_overrun;
   logic       rx_busy;
   logic       sp_in = 1'b1;
   logic       cnt_in = 1'b1;
   logic       sp_out;
   logic       cnt_out;

   int total = 0;
   int bad   = 0;
   bit ce_rand = 1'b0;

   fast_serial_peer #(.HALF_TICKS(HALF), .GAP_TICKS(GAP), .RX_TIMEOUT(RXTO)) dut (
      .clk        (clk),
      .res_n      (res_n),
      .ce         (ce),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_done    (tx_done),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ack     (rx_ack),
      .rx_overrun (rx_overrun),
      .rx_busy    (rx_busy),
      .sp_in      (sp_in),
      .cnt_in     (cnt_in),
      .sp_out     (sp_out),
      .cnt_out    (cnt_out)
   );

   always #5 clk = ~clk;

   // ce strobe: steady high unless a test asks for random gating.
   always @(negedge clk) begin
      if (ce_rand) ce = 1'($urandom_range(0, 1));
      else         ce = 1'b1;
   end

   // Host shifts one byte MSB first; the last rise is followed by a fixed tail where
   // rx_valid is observed just before and just after the expected 3-clk completion.
   task automatic send_byte(input logic [7:0] d, input int half, input bit ack_last,
                            output logic v_pre, output logic v_post);
      @(negedge clk);
      for (int i = 7; i >= 0; i--) begin
         cnt_in = 1'b0;
         sp_in  = d[i];
         repeat (half) @(negedge clk);
         cnt_in = 1'b1;
         if (i > 0) repeat (half) @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      v_pre = rx_valid;
      if (ack_last) rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      v_post = rx_valid;
      repeat (half) @(negedge clk);
   endtask

   task automatic ack_rx();
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
   endtask

   // Requests a transmit and follows the byte on sp_out/cnt_out until tx_done.
   task automatic tx_send_check(input logic [7:0] d, input bit gated);
      int n, ce_ticks, idx, lowlen, rises, stab_err, low_err, ready_err;
      logic [7:0] got;
      logic prev_cnt;
      n = 0; ce_ticks = 0; idx = -1; lowlen = 0; rises = 0;
      stab_err = 0; low_err = 0; ready_err = 0; got = 8'h00; prev_cnt = 1'b1;
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!tx_ready) begin
         bad++;
         tx_valid = 1'b0;
         $display("[TB] FAIL tx_accept: tx_ready=%b want 1 within 2000 clk", tx_ready);
      end else begin
         @(posedge clk);
         #1;
         tx_valid = 1'b0;
         n = 0;
         while (!tx_done && n < 1000) begin
            if (prev_cnt && !cnt_out) begin
               idx++;
               lowlen = 0;
            end
            if (!cnt_out) lowlen++;
            if (!prev_cnt && cnt_out) begin
               rises++;
               if (idx >= 0 && idx < 8) got[7-idx] = sp_out;
               if (!gated && lowlen != HALF) low_err++;
            end
            if (idx >= 0 && idx < 8 && (!cnt_out || idx < 7) && sp_out !== d[7-idx]) stab_err++;
            if (tx_ready) ready_err++;
            prev_cnt = cnt_out;
            @(posedge clk);
            #1;
            n++;
            if (ce) ce_ticks++;
         end
         total++;
         if (tx_done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL tx_done_seen: tx_done=%b want 1 within 1000 clk", tx_done);
         end
         total++;
         if (ce_ticks != 2 * HALF * 8 + GAP) begin
            bad++;
            $display("[TB] FAIL tx_done_ticks: got %0d ce ticks want %0d", ce_ticks, 2 * HALF * 8 + GAP);
         end
         total++;
         if (got !== d || rises != 8) begin
            bad++;
            $display("[TB] FAIL tx_bits: got %h (%0d rises) want %h (8 rises)", got, rises, d);
         end
         total++;
         if (stab_err != 0 || low_err != 0) begin
            bad++;
            $display("[TB] FAIL tx_waveform: sp errors %0d, low-width errors %0d, want 0/0", stab_err, low_err);
         end
         total++;
         if (ready_err != 0) begin
            bad++;
            $display("[TB] FAIL tx_ready_busy: tx_ready high %0d clk during byte, want 0", ready_err);
         end
         @(posedge clk);
         #1;
         total++;
         if ({tx_done, sp_out, cnt_out} !== 3'b011) begin
            bad++;
            $display("[TB] FAIL tx_after_done: done/sp/cnt=%b want 011", {tx_done, sp_out, cnt_out});
         end
      end
   endtask

   task automatic test_reset();
      res_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({sp_out, cnt_out, tx_ready, tx_done, rx_valid, rx_overrun, rx_busy, rx_data} !== {7'b1100000, 8'h00}) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %b want %b",
                  {sp_out, cnt_out, tx_ready, tx_done, rx_valid, rx_overrun, rx_busy, rx_data}, {7'b1100000, 8'h00});
      end
      res_n = 1'b1;
      #1;
      total++;
      if (tx_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_release_ready: tx_ready=%b want 0 before first edge", tx_ready);
      end
      @(posedge clk);
      #1;
      total++;
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_first_edge_ready: tx_ready=%b want 1", tx_ready);
      end
   endtask

   task automatic test_rx();
      logic vp, vq;
      logic [7:0] d;
      int half;
      send_byte(8'hA5, 5, 1'b0, vp, vq);
      total++;
      if ({vp, vq, rx_data} !== {2'b01, 8'hA5}) begin
         bad++;
         $display("[TB] FAIL rx_a5: valid pre/post=%b%b data=%h want 01 a5", vp, vq, rx_data);
      end
      ack_rx();
      total++;
      if (rx_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rx_ack_clears: rx_valid=%b want 0", rx_valid);
      end
      for (int k = 0; k < 4; k++) begin
         d    = 8'($urandom);
         half = $urandom_range(2, 6);
         send_byte(d, half, 1'b0, vp, vq);
         total++;
         if ({rx_valid, rx_busy, rx_data} !== {2'b10, d}) begin
            bad++;
            $display("[TB] FAIL rx_random: valid/busy=%b%b data=%h want 10 %h (half %0d)", rx_valid, rx_busy, rx_data, d, half);
         end
         ack_rx();
      end
   endtask

   task automatic test_tx();
      tx_send_check(8'h3C, 1'b0);
      tx_send_check(8'($urandom), 1'b0);
      ce_rand = 1'b1;
      tx_send_check(8'($urandom), 1'b1);
      tx_send_check(8'($urandom), 1'b1);
      ce_rand = 1'b0;
   endtask

   task automatic test_overrun();
      logic vp, vq;
      send_byte(8'h11, 3, 1'b0, vp, vq);
      send_byte(8'h22, 3, 1'b0, vp, vq);
      total++;
      if ({rx_valid, rx_overrun, rx_data} !== {2'b11, 8'h22}) begin
         bad++;
         $display("[TB] FAIL overrun_set: valid/ovr=%b%b data=%h want 11 22", rx_valid, rx_overrun, rx_data);
      end
      ack_rx();
      total++;
      if ({rx_valid, rx_overrun} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL overrun_ack_clears: valid/ovr=%b%b want 00", rx_valid, rx_overrun);
      end
      send_byte(8'h11, 3, 1'b0, vp, vq);
      send_byte(8'h22, 3, 1'b1, vp, vq);
      total++;
      if ({vq, rx_valid, rx_overrun, rx_data} !== {3'b110, 8'h22}) begin
         bad++;
         $display("[TB] FAIL overrun_ack_same_cycle: post/valid/ovr=%b%b%b data=%h want 110 22",
                  vq, rx_valid, rx_overrun, rx_data);
      end
      ack_rx();
   endtask

   task automatic test_timeout();
      logic vp, vq;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         cnt_in = 1'b0;
         sp_in  = 1'($urandom);
         repeat (4) @(negedge clk);
         cnt_in = 1'b1;
         if (i < 2) repeat (4) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      total++;
      if (rx_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL timeout_busy_start: rx_busy=%b want 1", rx_busy);
      end
      repeat (RXTO - 8) @(negedge clk);
      total++;
      if (rx_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL timeout_early: rx_busy=%b want 1 before timeout", rx_busy);
      end
      repeat (16) @(negedge clk);
      total++;
      if ({rx_busy, rx_valid} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL timeout_clear: busy/valid=%b%b want 00", rx_busy, rx_valid);
      end
      send_byte(8'hF0, 4, 1'b0, vp, vq);
      total++;
      if ({rx_valid, rx_data} !== {1'b1, 8'hF0}) begin
         bad++;
         $display("[TB] FAIL timeout_next_byte: valid=%b data=%h want 1 f0", rx_valid, rx_data);
      end
      ack_rx();
   endtask

   task automatic test_contention();
      logic vp, vq;
      logic [7:0] d, d2;
      int n;
      d  = 8'($urandom);
      d2 = 8'($urandom);
      fork
         send_byte(d, 3, 1'b0, vp, vq);
         begin
            repeat (14) @(negedge clk);
            total++;
            if (rx_busy !== 1'b1) begin
               bad++;
               $display("[TB] FAIL contention_busy: rx_busy=%b want 1", rx_busy);
            end
            tx_data  = 8'($urandom);
            tx_valid = 1'b1;
            n = 0;
            while (!tx_ready && n < 500) begin
               @(negedge clk);
               n++;
            end
            total++;
            if ({tx_ready, rx_busy, rx_valid, rx_data} !== {3'b101, d}) begin
               bad++;
               $display("[TB] FAIL contention_accept: ready/busy/valid=%b%b%b data=%h want 101 %h",
                        tx_ready, rx_busy, rx_valid, rx_data, d);
            end
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            for (int k = 0; k < 50; k++) begin
               @(negedge clk);
               cnt_in = 1'($urandom);
               sp_in  = 1'($urandom);
            end
            cnt_in = 1'b1;
            sp_in  = 1'b1;
            total++;
            if (rx_busy !== 1'b0) begin
               bad++;
               $display("[TB] FAIL contention_no_shift: rx_busy=%b want 0 during tx", rx_busy);
            end
            n = 0;
            while (!tx_done && n < 200) begin
               @(posedge clk);
               #1;
               n++;
            end
            total++;
            if ({tx_done, rx_valid, rx_busy, rx_data} !== {3'b110, d}) begin
               bad++;
               $display("[TB] FAIL contention_rx_kept: done/valid/busy=%b%b%b data=%h want 110 %h",
                        tx_done, rx_valid, rx_busy, rx_data, d);
            end
         end
      join
      ack_rx();
      send_byte(d2, 3, 1'b0, vp, vq);
      total++;
      if ({rx_valid, rx_data} !== {1'b1, d2}) begin
         bad++;
         $display("[TB] FAIL contention_next_byte: valid=%b data=%h want 1 %h", rx_valid, rx_data, d2);
      end
      ack_rx();
   endtask

   task automatic test_reset_mid_tx();
      logic [7:0] d;
      int n, dones;
      d = 8'($urandom);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      n = 0;
      while (!tx_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (26) @(posedge clk);
      #1;
      total++;
      if ({cnt_out, sp_out} !== {1'b0, d[4]}) begin
         bad++;
         $display("[TB] FAIL mid_tx_bit3: cnt/sp=%b%b want 0%b", cnt_out, sp_out, d[4]);
      end
      @(negedge clk);
      res_n = 1'b0;
      #1;
      total++;
      if ({sp_out, cnt_out, tx_ready, tx_done} !== 4'b1100) begin
         bad++;
         $display("[TB] FAIL mid_tx_reset: sp/cnt/ready/done=%b want 1100", {sp_out, cnt_out, tx_ready, tx_done});
      end
      @(negedge clk);
      res_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (tx_done) dones++;
      end
      total++;
      if (dones != 0 || tx_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL mid_tx_abandon: tx_done pulses=%0d ready=%b want 0 and 1", dones, tx_ready);
      end
      tx_send_check(8'($urandom), 1'b0);
   endtask

   initial begin
      test_reset();
      test_rx();
      test_tx();
      test_overrun();
      test_timeout();
      test_contention();
      test_reset_mid_tx();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
